// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the M-extension execute unit: opcode/funct
// encodings and the muldiv sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M execute unit. Operands are reduced to magnitudes at
// accept, one shift-add (multiply) or restoring (divide) step runs per CALC
// cycle on a shared accumulator, and the final sign is applied in FIX.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          r_state;
    md_state_e          w_state_next;

    logic [2:0]         r_funct3;
    logic [TAG_W-1:0]   r_tag;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {partial product, multiplier}. Divide: low half is dividend/quotient.
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN:0]      r_rem;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag_out;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic               w_neg;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_special;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic [XLEN-1:0]    w_special_res;
    logic               w_last;

    logic [XLEN:0]      w_mul_sum;
    logic [XLEN+1:0]    w_rem_sh;
    logic [XLEN+1:0]    w_trial;
    logic               w_qbit;

    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_fix_res;

    assign w_accept  = in_valid & ~flush & (r_state == IDLE);
    assign w_last    = (r_cnt == CNT_W'(XLEN - 1));
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;
    assign tag_out   = r_tag_out;

    // Operand decode: which inputs are signed, their magnitudes, result sign and special cases.
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                w_sa = rs1[XLEN-1];
                w_sb = rs2[XLEN-1];
            end
            F3_MULHSU: w_sa = rs1[XLEN-1];
            default: ;
        endcase
        w_mag_a    = w_sa ? -rs1 : rs1;
        w_mag_b    = w_sb ? -rs2 : rs2;
        // Remainder takes the dividend's sign; product and quotient take sA^sB.
        w_neg      = (funct3 == F3_REM) ? w_sa : (w_sa ^ w_sb);
        w_div_zero = funct3[2] && (rs2 == '0);
        w_div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (rs1 == MIN_INT) && (rs2 == '1);
        w_special  = w_div_zero | w_div_ovf;
        if (w_div_zero)
            w_special_res = funct3[1] ? rs1 : '1;
        else
            w_special_res = funct3[1] ? '0 : rs1;
    end

    // One iteration step for each algorithm plus the FIX-stage sign correction.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_rem_sh  = {r_rem, r_acc[XLEN-1]};
        w_trial   = w_rem_sh - {2'b00, r_mcand};
        w_qbit    = ~w_trial[XLEN+1];
        w_prod    = r_neg ? -r_acc : r_acc;
        w_quo     = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem     = r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        case (r_funct3)
            F3_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               w_fix_res = w_quo;
            default:                       w_fix_res = w_rem;
        endcase
    end

    // Next-state logic; flush returns any active operation to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_special ? DONE : CALC;
            CALC: begin
                if (flush)       w_state_next = IDLE;
                else if (w_last) w_state_next = FIX;
            end
            FIX:  w_state_next = flush ? IDLE : DONE;
            DONE: if (flush || out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Datapath: latch operands at accept, iterate in CALC, publish result in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3  <= '0;
            r_tag     <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_mcand   <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_funct3 <= funct3;
                    r_tag    <= tag_in;
                    r_neg    <= w_neg;
                    r_cnt    <= '0;
                    r_rem    <= '0;
                    r_acc    <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                    r_mcand  <= funct3[2] ? w_mag_b : w_mag_a;
                    if (w_special) begin
                        r_result  <= w_special_res;
                        r_tag_out <= tag_in;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_funct3[2]) begin
                        r_rem             <= w_qbit ? w_trial[XLEN:0] : w_rem_sh[XLEN:0];
                        r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], w_qbit};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    end
                end
                FIX: if (!flush) begin
                    r_result  <= w_fix_res;
                    r_tag_out <= r_tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vectors from the
// M-extension rules, handshake/flush/reset scenarios, then randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t dir_vec[15];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model straight from the RV32M arithmetic definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * {32'h0, b}; r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        if (ua < 0) r = '0; // ua is always non-negative; keeps the zero-extended copy in use
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 2;
    endfunction

    // Issue one op from IDLE, measure edges from accept to out_valid, check result/tag.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic [31:0] exp, input int exp_lat,
                          input bit release_out);
        int lat;
        in_valid = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        tag_in   = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("txn f3=%0d rs1=%h rs2=%h tag=%0d result=%h lat=%0d",
                 f3, a, b, t, result, lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", {32'h0, result}, {32'h0, exp});
        chk("tag_out", {59'h0, tag_out}, {59'h0, t});
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("in_ready_after_handshake", {63'h0, in_ready}, 64'd1);
            chk("out_valid_after_handshake", {63'h0, out_valid}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [31:0] corner[5];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;

        dir_vec[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        dir_vec[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 34};
        dir_vec[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        dir_vec[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        dir_vec[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34};
        dir_vec[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34};
        dir_vec[6]  = '{3'd5, 32'd100,       32'd7,        32'd14,       34};
        dir_vec[7]  = '{3'd7, 32'd100,       32'd7,        32'd2,        34};
        dir_vec[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF, 1};
        dir_vec[9]  = '{3'd7, 32'd5,         32'd0,        32'd5,        1};
        dir_vec[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        dir_vec[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1};
        dir_vec[12] = '{3'd4, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 1};
        dir_vec[13] = '{3'd6, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1};
        dir_vec[14] = '{3'd0, 32'd0,         32'd5,        32'd0,        34};

        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000;
        corner[4] = 32'h7FFFFFFF;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct3    = '0;
        rs1       = '0;
        rs2       = '0;
        tag_in    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  {63'h0, in_ready},  64'd1);
        chk("reset_out_valid", {63'h0, out_valid}, 64'd0);
        chk("reset_busy",      {63'h0, busy},      64'd0);
        chk("reset_result",    {32'h0, result},    64'd0);
        chk("reset_tag_out",   {59'h0, tag_out},   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 15; i++)
            run_op(dir_vec[i].f3, dir_vec[i].a, dir_vec[i].b, 5'(i + 3),
                   dir_vec[i].exp, dir_vec[i].lat, 1'b1);

        // Backpressure: result held in DONE, new requests ignored.
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            funct3   = 3'd0;
            rs1      = 32'd3;
            rs2      = 32'd3;
            tag_in   = 5'd1;
            @(posedge clk); #1;
            chk("bp_result",    {32'h0, result},    64'd14);
            chk("bp_tag",       {59'h0, tag_out},   64'd9);
            chk("bp_in_ready",  {63'h0, in_ready},  64'd0);
            chk("bp_busy",      {63'h0, busy},      64'd1);
            chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", {63'h0, in_ready}, 64'd1);
        chk("bp_release_busy",     {63'h0, busy},     64'd0);
        run_op(3'd0, 32'd12, 32'd11, 5'd17, 32'd132, 34, 1'b1);

        // Flush coinciding with a request blocks the accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        funct3   = 3'd5;
        rs1      = 32'd5;
        rs2      = 32'd0;
        tag_in   = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_busy", {63'h0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("flush_accept_out_valid", {63'h0, out_valid}, 64'd0);

        // Flush mid-CALC.
        in_valid = 1'b1;
        funct3   = 3'd4;
        rs1      = 32'd1000;
        rs2      = 32'd3;
        tag_in   = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_flush_busy", {63'h0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy",      {63'h0, busy},      64'd0);
        chk("flush_in_ready",  {63'h0, in_ready},  64'd1);
        chk("flush_out_valid", {63'h0, out_valid}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", {63'h0, seen}, 64'd0);
        run_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd6, 32'hFFFFFFFE, 34, 1'b1);

        // Reset asserted mid-CALC takes effect without a clock edge.
        in_valid = 1'b1;
        funct3   = 3'd0;
        rs1      = 32'd9;
        rs2      = 32'd9;
        tag_in   = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready",  {63'h0, in_ready},  64'd1);
        chk("rst_mid_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_mid_busy",      {63'h0, busy},      64'd0);
        chk("rst_mid_result",    {32'h0, result},    64'd0);
        chk("rst_mid_tag_out",   {59'h0, tag_out},   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5'd8, 32'hFFFFFFFF, 34, 1'b1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = 32'($urandom_range(0, 15));
                2:       ra = corner[$urandom_range(0, 4)];
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = corner[$urandom_range(0, 4)];
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb, 5'($urandom_range(0, 31)), ref_model(rf, ra, rb),
                   ref_latency(rf, ra, rb), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
